// File: rtl/switch_debounce_pkg.sv
// Shared types and default constants for the two-channel switch debouncer.
// Optional edge pulses are enabled with the DEBOUNCE_EDGE_PULSE_EN macro.
package switch_debounce_pkg;

   // Stable states carry the accepted level; pending states carry the level being left.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      P1 = 2'b01,
      S1 = 2'b10,
      P0 = 2'b11
   } chan_state_t;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_DEB_CYCLES = 50000;

   function automatic logic level_of(input chan_state_t s);
      return (s == S1) || (s == P0);
   endfunction

endpackage

// File: rtl/switch_debounce_2ch_channel.sv
// One switch line: 2-FF synchronizer, qualification counter and 4-state FSM.
// Rise/fall pulse outputs exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_channel
   import switch_debounce_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
`ifdef DEBOUNCE_EDGE_PULSE_EN
   ,
   output logic rise,
   output logic fall
`endif
);

   localparam longint MAX_CYCLES = (longint'(1) << CNT_W) - 1;

   if (DEB_CYCLES < 1 || longint'(DEB_CYCLES) > MAX_CYCLES) begin : g_range_err
      $error("debounce_channel: DEB_CYCLES=%0d outside 1..2**CNT_W-1", DEB_CYCLES);
   end

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   chan_state_t      state;
   chan_state_t      next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S0: begin
            if (sync2) begin
               next_state = P1;
               next_cnt   = '0;
            end
         end
         P1: begin
            if (!sync2)           next_state = S0;
            else if (cnt == TERM) next_state = S1;
            else                  next_cnt   = cnt + 1'b1;
         end
         S1: begin
            if (!sync2) begin
               next_state = P0;
               next_cnt   = '0;
            end
         end
         P0: begin
            if (sync2)            next_state = S1;
            else if (cnt == TERM) next_state = S0;
            else                  next_cnt   = cnt + 1'b1;
         end
         default: begin
            next_state = S0;
            next_cnt   = '0;
         end
      endcase
   end

   // Output is registered from the next state so it changes on the same edge
   // the FSM commits to the new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         level <= level_of(next_state);
      end
   end

`ifdef DEBOUNCE_EDGE_PULSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= (state == P1) && (next_state == S1);
         fall <= (state == P0) && (next_state == S0);
      end
   end
`endif

endmodule

// File: rtl/switch_debounce_2ch.sv
// Two independent debounced switch inputs feeding the gate block's a and b.
// Define DEBOUNCE_EDGE_PULSE_EN to add a_rise/a_fall/b_rise/b_fall pulses.
module switch_debounce_2ch
   import switch_debounce_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_a,
   input  logic sw_b,
   output logic a,
   output logic b
`ifdef DEBOUNCE_EDGE_PULSE_EN
   ,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall
`endif
);

   debounce_channel #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_chan_a (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_a),
      .level (a)
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .rise  (a_rise),
      .fall  (a_fall)
`endif
   );

   debounce_channel #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_chan_b (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_b),
      .level (b)
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .rise  (b_rise),
      .fall  (b_fall)
`endif
   );

endmodule
